alu_fpu_exec: RTL and testbench
===============================

ALU_FPU_EXEC -- requirements
Module: alu_fpu_exec

Interface
REQ-001 Parameter INT_LAT, default 1, cycles from request acceptance to rsp_valid for integer ops (legal range 1..15).
REQ-002 Parameter FP_LAT, default 4, cycles from request acceptance to rsp_valid for float ops (legal range 1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_a, req_b  input  64 each  operands; IEEE-754 double when req_is_float=1.
REQ-009 req_op  input  4  opcode: 0=ADD, 1=SUB, 2=MUL; all other codes are illegal.
REQ-010 req_is_float  input  1  selects FP (1) or integer (0) arithmetic.
REQ-011 req_tag  input  5  caller ID, returned unchanged with the response.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_result  output  64  operation result.
REQ-015 rsp_tag  output  5  tag of the completed request.
REQ-016 rsp_err  output  1  response is for an illegal opcode.
REQ-017 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 Request handshake SHALL occur on a rising edge where req_valid=1 and req_ready=1; operands, op, is_float and tag are latched at that edge.
REQ-019 FSM states SHALL be IDLE, EXEC and DONE; at most one operation is in flight.
REQ-020 req_ready SHALL be 1 in IDLE, 1 in DONE when rsp_ready=1, and 0 otherwise.
REQ-021 On acceptance the FSM SHALL enter EXEC and load a down-counter with FP_LAT-1 if is_float=1, else INT_LAT-1.
REQ-022 In EXEC with counter=0, the FSM SHALL register the alu_fpu output into rsp_result, the latched tag into rsp_tag, and enter DONE.
REQ-023 rsp_valid SHALL be high exactly in DONE; a request accepted at edge N yields rsp_valid high from edge N+LAT.
REQ-024 In DONE, rsp_result, rsp_tag and rsp_err SHALL hold stable until the response handshake completes (rsp_valid=1 and rsp_ready=1).
REQ-025 On the response handshake the FSM SHALL go to IDLE, or, if req_valid=1 in the same cycle, accept the new request and go to EXEC (back-to-back, no bubble).
REQ-026 An illegal opcode SHALL use INT_LAT latency and return rsp_err=1 with rsp_result=0; legal ops return rsp_err=0.
REQ-027 Integer ADD/SUB/MUL SHALL be modulo 2^64 (low 64 bits kept, no overflow flag); FP results are exactly those of alu_fpu.
REQ-028 req_valid SHALL be ignored while req_ready=0; no request is queued or dropped silently, because the caller holds it.

Reset
REQ-029 While rst_n=0: FSM=IDLE, counter=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0, busy=0; req_ready=1 after release.
REQ-030 Reset asserted mid-EXEC or mid-DONE SHALL abort the operation; no response is ever produced for it.

Structure
REQ-031 Package alu_fpu_pkg SHALL hold the opcode constants (ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_MUL=4'h2), the FSM state enum, and the default latency constants.
REQ-032 The block SHALL instantiate the existing combinational alu_fpu as its single sub-module, fed from the latched operand registers.

Verification
REQ-033 Int ADD a=10, b=20, tag=3, rsp_ready=1 -> rsp_valid one cycle after acceptance, result=30, tag=3, err=0.
REQ-034 FP MUL a=0x4008000000000000 (3.0), b=0x4000000000000000 (2.0) -> result 0x4018000000000000 (6.0) exactly 4 cycles after acceptance.
REQ-035 FP ADD 1.5+2.25 with rsp_ready=0 for 5 cycles -> rsp_valid held, result 0x400E000000000000 stable, req_ready=0 until the handshake.
REQ-036 Int SUB 30-10 followed by int SUB 0-1 presented back-to-back -> results 20 then 0xFFFFFFFFFFFFFFFF, second accepted on the first response's handshake edge.
REQ-037 req_op=4'h7 -> rsp_err=1, result=0 after INT_LAT; then rst_n pulsed low during an FP op in EXEC -> no rsp_valid, busy=0, req_ready=1 after release.

Source files
------------

// File: rtl/alu_fpu_pkg.sv
// Shared opcodes, FSM state encoding and default latencies for the integer/FP
// execution block.
package alu_fpu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;

  localparam int INT_LAT_DEF = 1;
  localparam int FP_LAT_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] FP_QNAN = 64'h7FF8_0000_0000_0000;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_fpu_exec_if.sv
// Request/response handshake bundle between a caller and alu_fpu_exec.
interface alu_fpu_exec_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_op;
  logic        req_is_float;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_is_float, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_is_float, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_fpu.sv
// Combinational 64-bit integer / IEEE-754 double ADD, SUB, MUL (round to nearest
// even). Subnormal inputs and results are flushed to signed zero.
module alu_fpu
  import alu_fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  op,
  input  logic        is_float,
  output logic [63:0] result,
  output logic        err
);

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == '0);
  endfunction

  // m carries the normalised significand at bit 55 plus guard, round, sticky.
  function automatic logic [63:0] round_pack(input logic s, input int e_in, input logic [55:0] m);
    int          e;
    logic        up;
    logic [53:0] rnd;
    e   = e_in;
    up  = m[2] & (m[1] | m[0] | m[3]);
    rnd = {1'b0, m[55:3]} + 54'(up);
    if (rnd[53]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end
    if (e >= 2047) return {s, 11'h7FF, 52'd0};
    if (e <= 0)    return {s, 63'd0};
    return {s, 11'(e), rnd[51:0]};
  endfunction

  function automatic logic [63:0] fp_add(input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] x, y;
    logic [55:0] xa, xb, mask;
    logic [56:0] s;
    int          d, e, lz;
    logic        found;
    if (is_nan(a_in) || is_nan(b_in)) return FP_QNAN;
    if (is_inf(a_in)) return (is_inf(b_in) && (a_in[63] != b_in[63])) ? FP_QNAN : a_in;
    if (is_inf(b_in)) return b_in;
    if (a_in[62:52] == '0 && b_in[62:52] == '0) return {a_in[63] & b_in[63], 63'd0};
    if (a_in[62:52] == '0) return b_in;
    if (b_in[62:52] == '0) return a_in;
    // Order by magnitude so only the smaller operand is aligned.
    x = (b_in[62:0] > a_in[62:0]) ? b_in : a_in;
    y = (b_in[62:0] > a_in[62:0]) ? a_in : b_in;
    d  = int'(x[62:52]) - int'(y[62:52]);
    xa = {1'b1, x[51:0], 3'b000};
    if (d > 55) begin
      xb = 56'd1;
    end else begin
      mask = (56'd1 << d) - 56'd1;
      xb   = ({1'b1, y[51:0], 3'b000} >> d) | 56'(|({1'b1, y[51:0], 3'b000} & mask));
    end
    s = (x[63] == y[63]) ? ({1'b0, xa} + {1'b0, xb}) : ({1'b0, xa} - {1'b0, xb});
    if (s == '0) return 64'd0;
    e = int'(x[62:52]);
    if (s[56]) begin
      s = {1'b0, s[56:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int i = 55; i >= 0; i--) begin
        if (!found && s[i]) begin
          lz    = 55 - i;
          found = 1'b1;
        end
      end
      s = s << lz;
      e = e - lz;
    end
    return round_pack(x[63], e, s[55:0]);
  endfunction

  function automatic logic [63:0] fp_mul(input logic [63:0] a_in, input logic [63:0] b_in);
    logic         s;
    logic [105:0] p;
    int           e;
    s = a_in[63] ^ b_in[63];
    if (is_nan(a_in) || is_nan(b_in)) return FP_QNAN;
    if (is_inf(a_in) || is_inf(b_in))
      return (a_in[62:52] == '0 || b_in[62:52] == '0) ? FP_QNAN : {s, 11'h7FF, 52'd0};
    if (a_in[62:52] == '0 || b_in[62:52] == '0) return {s, 63'd0};
    p = 106'({1'b1, a_in[51:0]}) * 106'({1'b1, b_in[51:0]});
    e = int'(a_in[62:52]) + int'(b_in[62:52]) - 1023;
    if (p[105]) e = e + 1;
    else        p = p << 1;
    return round_pack(s, e, {p[105:51], |p[50:0]});
  endfunction

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_ADD: result = is_float ? fp_add(a, b) : a + b;
      ALU_SUB: result = is_float ? fp_add(a, {~b[63], b[62:0]}) : a - b;
      ALU_MUL: result = is_float ? fp_mul(a, b) : a * b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_fpu_exec.sv
// Single-issue execution wrapper: latches one request, waits a fixed per-type
// latency, then holds the response until the consumer takes it.
module alu_fpu_exec
  import alu_fpu_pkg::*;
#(
  parameter int INT_LAT = INT_LAT_DEF,
  parameter int FP_LAT  = FP_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_fpu_exec_if.slave bus,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam logic [3:0] INT_CNT = 4'(INT_LAT - 1);
  localparam logic [3:0] FP_CNT  = 4'(FP_LAT - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        float_q;
  logic [4:0]  tag_q;
  logic [63:0] alu_result, rsp_result_q;
  logic        alu_err, rsp_err_q;
  logic [4:0]  rsp_tag_q;
  logic        accept;
  logic [3:0]  load_cnt;

  assign bus.req_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.rsp_ready);
  assign bus.rsp_valid  = (state == S_DONE);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != S_IDLE);
  assign accept         = bus.req_valid && bus.req_ready;
  // Illegal opcodes complete on the integer schedule even when flagged float.
  assign load_cnt       = (bus.req_is_float && op_legal(bus.req_op)) ? FP_CNT : INT_CNT;

  // NOTE: operand registers carry no reset; they are only consumed after an
  // acceptance has loaded them, so a reset value would never be observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      op_q    <= bus.req_op;
      float_q <= bus.req_is_float;
      tag_q   <= bus.req_tag;
    end
  end

  alu_fpu u_alu_fpu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .is_float (float_q),
    .result   (alu_result),
    .err      (alu_err)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_EXEC;
          cnt   <= load_cnt;
        end
        S_EXEC: if (cnt == '0) begin
          state        <= S_DONE;
          rsp_result_q <= alu_result;
          rsp_tag_q    <= tag_q;
          rsp_err_q    <= alu_err;
        end else begin
          cnt <= cnt - 4'd1;
        end
        S_DONE: if (bus.rsp_ready) begin
          if (accept) begin
            state <= S_EXEC;
            cnt   <= load_cnt;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fpu_exec.sv
// Self-checking bench for alu_fpu_exec: directed scenarios plus random traffic
// compared against a real-arithmetic reference model.
module tb_alu_fpu_exec;
  import alu_fpu_pkg::*;

  localparam int INT_LAT = 1;
  localparam int FP_LAT  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  alu_fpu_exec_if bus ();

  alu_fpu_exec #(.INT_LAT(INT_LAT), .FP_LAT(FP_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit integer arithmetic or host IEEE double arithmetic.
  function automatic void model(input logic [3:0] op, input logic fl, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res,
                                output logic err, output int lat);
    real ra, rb;
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    err = 1'b0;
    lat = fl ? FP_LAT : INT_LAT;
    case (op)
      4'd0:    res = fl ? $realtobits(ra + rb) : a + b;
      4'd1:    res = fl ? $realtobits(ra - rb) : a - b;
      4'd2:    res = fl ? $realtobits(ra * rb) : a * b;
      default: begin res = 64'd0; err = 1'b1; lat = INT_LAT; end
    endcase
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] r;
    r[63]    = 1'($urandom_range(0, 1));
    r[62:52] = 11'($urandom_range(1023 - 40, 1023 + 40));
    r[51:32] = 20'($urandom);
    r[31:0]  = $urandom;
    return r;
  endfunction

  task automatic drive_req(input logic [3:0] op, input logic fl, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
    bus.req_op       = op;
    bus.req_is_float = fl;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_tag      = tag;
    bus.req_valid    = 1'b1;
  endtask

  // Issue one request from IDLE, stall the response 'stall' cycles, then take it.
  task automatic run_op(input logic [3:0] op, input logic fl, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int stall,
                        output logic [63:0] got);
    logic [63:0] exp_res;
    logic        exp_err;
    int          lat, n;
    model(op, fl, a, b, exp_res, exp_err, lat);
    drive_req(op, fl, a, b, tag);
    bus.rsp_ready = (stall == 0);
    #1;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_tag   = ~tag;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.rsp_valid && n < 40);
    check("latency", 64'(n), 64'(lat));
    got = bus.rsp_result;
    check("result", bus.rsp_result, exp_res);
    check("tag", 64'(bus.rsp_tag), 64'(tag));
    check("err", 64'(bus.rsp_err), 64'(exp_err));
    check("busy_done", 64'(busy), 64'd1);
    check("req_ready_done", 64'(bus.req_ready), 64'(stall == 0));
    for (int s = 0; s < stall; s++) begin
      step();
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_result", bus.rsp_result, exp_res);
      check("hold_tag", 64'(bus.rsp_tag), 64'(tag));
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("req_ready_hs", 64'(bus.req_ready), 64'd1);
    step();
    bus.rsp_ready = 1'b0;
    check("idle_after", {62'd0, busy, bus.rsp_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] got, a, b;
    logic [3:0]  op;
    logic        fl;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.req_is_float = 1'b0; bus.req_tag = '0; bus.rsp_ready = 1'b0;
    #2;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", bus.rsp_result, 64'd0);
    check("rst_tag", 64'(bus.rsp_tag), 64'd0);
    check("rst_err", 64'(bus.rsp_err), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    step();

    // Integer ADD with immediate consumer
    run_op(ALU_ADD, 1'b0, 64'd10, 64'd20, 5'd3, 0, got);
    check("int_add_30", got, 64'd30);

    // FP MUL 3.0 * 2.0
    run_op(ALU_MUL, 1'b1, 64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd5, 0, got);
    check("fp_mul_6", got, 64'h4018_0000_0000_0000);

    // FP ADD 1.5 + 2.25 with a stalled consumer
    run_op(ALU_ADD, 1'b1, 64'h3FF8_0000_0000_0000, 64'h4002_0000_0000_0000, 5'd7, 5, got);
    check("fp_add_3p75", got, 64'h400E_0000_0000_0000);

    // Back-to-back integer SUBs, second accepted on the first response handshake
    drive_req(ALU_SUB, 1'b0, 64'd30, 64'd10, 5'd9);
    bus.rsp_ready = 1'b1;
    step();
    drive_req(ALU_SUB, 1'b0, 64'd0, 64'd1, 5'd10);
    step();
    check("b2b_first_valid", 64'(bus.rsp_valid), 64'd1);
    check("b2b_first_result", bus.rsp_result, 64'd20);
    check("b2b_first_tag", 64'(bus.rsp_tag), 64'd9);
    check("b2b_ready", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    check("b2b_exec_novalid", 64'(bus.rsp_valid), 64'd0);
    check("b2b_exec_busy", 64'(busy), 64'd1);
    step();
    check("b2b_second_valid", 64'(bus.rsp_valid), 64'd1);
    check("b2b_second_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_second_tag", 64'(bus.rsp_tag), 64'd10);
    step();
    bus.rsp_ready = 1'b0;
    check("b2b_idle", 64'(busy), 64'd0);

    // Illegal opcode
    run_op(4'h7, 1'b0, 64'd123, 64'd456, 5'd11, 1, got);
    check("illegal_zero", got, 64'd0);

    // Reset in the middle of an FP op aborts it
    drive_req(ALU_MUL, 1'b1, 64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd4);
    bus.rsp_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    check("abort_busy_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_rst_busy", 64'(busy), 64'd0);
    check("abort_rst_result", bus.rsp_result, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_rsp", {62'd0, busy, bus.rsp_valid}, 64'd0);
    end
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    bus.rsp_ready = 1'b0;

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      fl = 1'($urandom_range(0, 1));
      if (fl) begin
        a = rand_fp();
        b = rand_fp();
        if ($urandom_range(0, 3) == 0) begin
          b = a;
          b[7:0] = 8'($urandom);
          b[63] = (op == ALU_SUB) ? a[63] : ~a[63];
        end
      end else begin
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      end
      run_op(op, fl, a, b, 5'($urandom), int'($urandom_range(0, 3)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
